// File: rtl/multi_des_chain_ctrl_if.sv
// Host and DES-core signal bundle for the chained DES sequencer.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready handshakes; core side is enable/done pulses.
interface multi_des_chain_ctrl_if #(
    parameter int N_STAGES = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    encr_decr;
    logic                    two_key;
    logic [63:0]             data_in;
    logic [64*N_STAGES-1:0]  keys;
    logic                    out_valid;
    logic                    out_ready;
    logic [63:0]             data_out;
    logic                    err;
    logic                    busy;
    logic                    core_enable;
    logic                    core_encr_decr;
    logic [63:0]             core_key;
    logic [63:0]             core_data_in;
    logic [63:0]             core_data_out;
    logic                    core_done;

    modport slave (
        input  in_valid, encr_decr, two_key, data_in, keys, out_ready,
               core_data_out, core_done,
        output in_ready, out_valid, data_out, err, busy,
               core_enable, core_encr_decr, core_key, core_data_in
    );

    modport master (
        output in_valid, encr_decr, two_key, data_in, keys, out_ready,
               core_data_out, core_done,
        input  in_ready, out_valid, data_out, err, busy,
               core_enable, core_encr_decr, core_key, core_data_in
    );
endinterface

// File: rtl/multi_des_chain_ctrl.sv
// Drives one external DES core N_STAGES times per block (alternating E/D), with per-stage watchdog.
// Latency: sum over stages of (1 + core latency) cycles from accept to out_valid.
// Backpressure: in_ready only in IDLE; result held in OUT until out_ready.
module multi_des_chain_ctrl #(
    parameter int N_STAGES       = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    multi_des_chain_ctrl_if.slave bus
);
    localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_OUT} state_t;

    state_t                  state_q;
    logic [SW-1:0]           stage_q;
    logic [TW-1:0]           tmr_q;
    logic [63:0]             work_q;
    logic [64*N_STAGES-1:0]  keys_q;
    logic                    dir_q;
    logic                    two_key_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    err_q;
    logic                    busy_q;
    logic                    core_enable_q;
    logic                    core_dir_q;
    logic [63:0]             core_key_q;

    logic [63:0]             core_key_d;
    logic                    core_dir_d;

    // Key/direction for the stage about to start: stage 0 from the live inputs
    // at accept, later stages from the latched copies.
    always_comb begin
        int                     j;
        int                     k;
        logic                   enc;
        logic                   tk;
        logic [64*N_STAGES-1:0] ks;
        if (state_q == S_IDLE) begin
            j   = 0;
            enc = bus.encr_decr;
            tk  = bus.two_key;
            ks  = bus.keys;
        end else begin
            j   = int'(stage_q) + 1;
            enc = dir_q;
            tk  = two_key_q;
            ks  = keys_q;
        end
        k          = enc ? j : (N_STAGES - 1 - j);
        core_dir_d = enc ? (j % 2 == 0) : (k % 2 == 1);
        if ((tk && (N_STAGES > 1) && (k == N_STAGES - 1)) || (k < 0) || (k >= N_STAGES))
            k = 0;
        core_key_d = ks[64*k +: 64];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= S_IDLE;
            stage_q       <= '0;
            tmr_q         <= '0;
            work_q        <= '0;
            keys_q        <= '0;
            dir_q         <= 1'b0;
            two_key_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            core_enable_q <= 1'b0;
            core_dir_q    <= 1'b0;
            core_key_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        work_q        <= bus.data_in;
                        keys_q        <= bus.keys;
                        dir_q         <= bus.encr_decr;
                        two_key_q     <= bus.two_key;
                        stage_q       <= '0;
                        in_ready_q    <= 1'b0;
                        busy_q        <= 1'b1;
                        core_enable_q <= 1'b1;
                        core_key_q    <= core_key_d;
                        core_dir_q    <= core_dir_d;
                        state_q       <= S_RUN;
                    end
                end
                S_RUN: begin
                    core_enable_q <= 1'b0;
                    tmr_q         <= '0;
                    state_q       <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the expiry cycle still counts as success.
                    if (bus.core_done) begin
                        work_q <= bus.core_data_out;
                        if (stage_q == SW'(N_STAGES - 1)) begin
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_OUT;
                        end else begin
                            stage_q       <= stage_q + SW'(1);
                            core_enable_q <= 1'b1;
                            core_key_q    <= core_key_d;
                            core_dir_q    <= core_dir_d;
                            state_q       <= S_RUN;
                        end
                    end else if (tmr_q == TW'(TIMEOUT_CYCLES)) begin
                        err_q       <= 1'b1;
                        work_q      <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.data_out       = work_q;
    assign bus.err            = err_q;
    assign bus.busy           = busy_q;
    assign bus.core_enable    = core_enable_q;
    assign bus.core_encr_decr = core_dir_q;
    assign bus.core_key       = core_key_q;
    assign bus.core_data_in   = work_q;
endmodule

// File: tb/tb_multi_des_chain_ctrl.sv
// Bench for the chained DES sequencer: timeline model of each block plus a DES core model.
// Latency: n/a. Backpressure: exercised by holding out_ready low and toggling in_valid while busy.
module tb_multi_des_chain_ctrl;
    localparam int N = 3;
    localparam int T = 8;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    multi_des_chain_ctrl_if #(.N_STAGES(N)) bus ();
    multi_des_chain_ctrl #(.N_STAGES(N), .TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    localparam int IP_T[64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,
        59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int FP_T[64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,
        35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    localparam int E_T[48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
        16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int P_T[32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
        2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1_T[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,
        59,51,43,35,27,19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,
        30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2_T[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
        26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,
        34,53,46,42,50,36,29,32};
    localparam int SH_T[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int S_T[512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [63:0] des(input logic [63:0] key, input logic [63:0] blk, input bit enc);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] sk[16];
        logic [47:0] e;
        logic [63:0] b, pre, res;
        logic [31:0] l, r, t, so, f;
        logic [5:0]  six;
        int          idx;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int rd = 0; rd < 16; rd++) begin
            for (int s = 0; s < SH_T[rd]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) sk[rd][47-i] = cd[56-PC2_T[i]];
        end
        for (int i = 0; i < 64; i++) b[63-i] = blk[64-IP_T[i]];
        l = b[63:32];
        r = b[31:0];
        for (int rd = 0; rd < 16; rd++) begin
            for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
            e = e ^ (enc ? sk[rd] : sk[15-rd]);
            for (int j = 0; j < 8; j++) begin
                six = e[47-6*j -: 6];
                idx = j*64 + int'({six[5], six[0]})*16 + int'(six[4:1]);
                so[31-4*j -: 4] = 4'(S_T[idx]);
            end
            for (int i = 0; i < 32; i++) f[31-i] = so[32-P_T[i]];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
        return res;
    endfunction

    int vectors = 0;
    int miscompares = 0;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected values for the current cycle, maintained by the driver.
    bit          chk_en = 1'b0;
    logic        e_in_ready, e_busy, e_out_valid, e_err, e_core_en, e_core_chk, e_core_dir;
    logic [63:0] e_data, e_core_key, e_core_data;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk64("in_ready", bus.in_ready, e_in_ready);
            chk64("busy", bus.busy, e_busy);
            chk64("out_valid", bus.out_valid, e_out_valid);
            chk64("err", bus.err, e_err);
            chk64("core_enable", bus.core_enable, e_core_en);
            if (e_out_valid) chk64("data_out", bus.data_out, e_data);
            if (e_core_chk) begin
                chk64("core_key", bus.core_key, e_core_key);
                chk64("core_encr_decr", bus.core_encr_decr, e_core_dir);
                chk64("core_data_in", bus.core_data_in, e_core_data);
            end
        end
    end

    logic [63:0] last_out;
    logic        last_err;
    logic [63:0] seen_key[N];
    logic        seen_dir[N];

    task automatic set_idle_exp();
        e_in_ready = 1'b1; e_busy = 1'b0; e_out_valid = 1'b0; e_err = 1'b0;
        e_core_en = 1'b0; e_core_chk = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid      = 1'b0;
            bus.core_done     = 1'($urandom);
            bus.core_data_out = {$urandom, $urandom};
            set_idle_exp();
            @(posedge clk); #1;
        end
    endtask

    // One block: dl = WAIT cycles until core_done per stage (0 = core never answers).
    task automatic run_block(input bit enc, input bit tk, input logic [63:0] din,
                             input logic [64*N-1:0] ks, input int da, input int db,
                             input int dc, input int hold, input int rst_at);
        int          dl[N];
        int          s[N];
        int          w[N];
        logic [63:0] sin[N];
        logic [63:0] skey[N];
        bit          sdir[N];
        int          len, nst, k;
        bit          errf;
        logic [63:0] x;
        dl[0] = da; dl[1] = db; dl[2] = dc;
        x = din; len = 0; nst = 0; errf = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!errf) begin
                k       = enc ? j : N - 1 - j;
                sdir[j] = enc ? (j % 2 == 0) : (k % 2 == 1);
                skey[j] = (tk && k == N - 1) ? ks[63:0] : ks[64*k +: 64];
                sin[j]  = x;
                s[j]    = len;
                nst     = j + 1;
                if (dl[j] == 0) begin
                    w[j] = T + 1;
                    errf = 1'b1;
                end else begin
                    w[j] = dl[j];
                    x    = des(skey[j], x, sdir[j]);
                end
                len += 1 + w[j];
            end
        end
        bus.in_valid  = 1'b1;
        bus.data_in   = din;
        bus.keys      = ks;
        bus.encr_decr = enc;
        bus.two_key   = tk;
        bus.core_done = 1'b0;
        bus.out_ready = 1'($urandom);
        set_idle_exp();
        @(posedge clk); #1;
        for (int c = 0; c <= len + hold; c++) begin
            bus.in_valid      = 1'($urandom);
            bus.data_in       = {$urandom, $urandom};
            bus.keys          = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            bus.encr_decr     = 1'($urandom);
            bus.two_key       = 1'($urandom);
            bus.core_done     = (c >= len) ? 1'($urandom) : 1'b0;
            bus.core_data_out = {$urandom, $urandom};
            e_core_en  = 1'b0;
            e_core_chk = 1'b0;
            for (int j = 0; j < nst; j++) begin
                if (c == s[j]) begin
                    e_core_en     = 1'b1;
                    bus.core_done = 1'($urandom);
                end
                if (c >= s[j] && c <= s[j] + w[j]) begin
                    e_core_chk  = 1'b1;
                    e_core_key  = skey[j];
                    e_core_dir  = sdir[j];
                    e_core_data = sin[j];
                end
                if (dl[j] > 0 && c == s[j] + dl[j]) begin
                    bus.core_done     = 1'b1;
                    bus.core_data_out = des(skey[j], sin[j], sdir[j]);
                end
            end
            bus.out_ready = (c < len) ? 1'($urandom) : (c == len + hold);
            e_in_ready  = 1'b0;
            e_busy      = (c < len);
            e_out_valid = (c >= len);
            e_err       = (c >= len) && errf;
            e_data      = errf ? 64'h0 : x;
            if (c == rst_at) begin
                #2 nrst = 1'b0;
                #1;
                chk64("rst_in_ready", bus.in_ready, 64'h1);
                chk64("rst_out_valid", bus.out_valid, 64'h0);
                chk64("rst_err", bus.err, 64'h0);
                chk64("rst_busy", bus.busy, 64'h0);
                chk64("rst_core_enable", bus.core_enable, 64'h0);
                chk64("rst_data_out", bus.data_out, 64'h0);
                set_idle_exp();
                bus.in_valid  = 1'b0;
                bus.core_done = 1'b0;
                @(posedge clk);
                #2 nrst = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            for (int j = 0; j < nst; j++)
                if (c == s[j]) begin
                    seen_key[j] = bus.core_key;
                    seen_dir[j] = bus.core_encr_decr;
                end
            if (c == len + hold) begin
                last_out = bus.data_out;
                last_err = bus.err;
            end
            @(posedge clk); #1;
        end
    endtask

    localparam logic [63:0] K  = 64'h133457799BBCDFF1;
    localparam logic [63:0] D  = 64'h0123456789ABCDEF;
    localparam logic [63:0] P  = 64'h4E6F772069732074;
    localparam logic [63:0] KA = 64'h0123456789ABCDEF;
    localparam logic [63:0] KB = 64'h23456789ABCDEF01;
    localparam logic [63:0] KC = 64'h456789ABCDEF0123;

    initial begin
        logic [63:0] ct, r1;
        int          dd[3];
        nrst = 1'b1;
        bus.in_valid = 1'b0; bus.encr_decr = 1'b0; bus.two_key = 1'b0;
        bus.data_in = '0; bus.keys = '0; bus.out_ready = 1'b0;
        bus.core_data_out = '0; bus.core_done = 1'b0;
        #2 nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk64("reset_in_ready", bus.in_ready, 64'h1);
        chk64("reset_out_valid", bus.out_valid, 64'h0);
        chk64("reset_err", bus.err, 64'h0);
        chk64("reset_busy", bus.busy, 64'h0);
        chk64("reset_core_enable", bus.core_enable, 64'h0);
        chk64("reset_core_dir", bus.core_encr_decr, 64'h0);
        chk64("reset_data_out", bus.data_out, 64'h0);
        chk64("reset_core_key", bus.core_key, 64'h0);
        #2 nrst = 1'b1;
        @(posedge clk); #1;
        set_idle_exp();
        chk_en = 1'b1;
        idle(2);

        // Single-key EDE collapses to plain DES: known-answer vector.
        run_block(1'b1, 1'b0, D, {K, K, K}, 2, 3, 1, 0, -1);
        chk64("kat_out", last_out, 64'h85E813540F0AB405);
        chk64("kat_err", last_err, 64'h0);
        idle(1);

        // Three-key encrypt then decrypt round trip, with stage mapping pinned.
        run_block(1'b1, 1'b0, P, {KC, KB, KA}, 1, 4, 2, 1, -1);
        ct = last_out;
        chk64("enc_key0", seen_key[0], KA);
        chk64("enc_key1", seen_key[1], KB);
        chk64("enc_key2", seen_key[2], KC);
        chk64("enc_dirs", {seen_dir[0], seen_dir[1], seen_dir[2]}, 64'b101);
        run_block(1'b0, 1'b0, ct, {KC, KB, KA}, 3, 1, 5, 0, -1);
        chk64("roundtrip", last_out, P);
        chk64("dec_key0", seen_key[0], KC);
        chk64("dec_key1", seen_key[1], KB);
        chk64("dec_key2", seen_key[2], KA);
        chk64("dec_dirs", {seen_dir[0], seen_dir[1], seen_dir[2]}, 64'b010);

        // Two-key mode: last stage reuses key 0.
        run_block(1'b1, 1'b1, P, {KC, KB, KA}, 2, 2, 2, 0, -1);
        r1 = last_out;
        chk64("two_key_k2", seen_key[2], KA);
        run_block(1'b1, 1'b0, P, {KA, KB, KA}, 1, 1, 1, 0, -1);
        chk64("two_key_eq", last_out, r1);

        // Core silent on stage 0: watchdog abort, then a clean block.
        run_block(1'b1, 1'b0, P, {KC, KB, KA}, 0, 1, 1, 2, -1);
        chk64("timeout_err", last_err, 64'h1);
        chk64("timeout_data", last_out, 64'h0);
        run_block(1'b1, 1'b0, D, {K, K, K}, 1, 1, 1, 0, -1);
        chk64("after_timeout_err", last_err, 64'h0);
        chk64("after_timeout_out", last_out, 64'h85E813540F0AB405);

        // done on the expiry cycle still wins; timeout on a later stage.
        run_block(1'b0, 1'b0, P, {KC, KB, KA}, T + 1, 1, T + 1, 0, -1);
        chk64("tie_err", last_err, 64'h0);
        run_block(1'b1, 1'b0, P, {KC, KB, KA}, 2, 0, 1, 0, -1);
        chk64("stage1_timeout_err", last_err, 64'h1);

        // Long out_ready stall with in_valid noise.
        run_block(1'b1, 1'b1, D, {KA, KB, KC}, 1, 2, 3, 20, -1);

        // Reset during stage-1 WAIT, then a correct block.
        run_block(1'b1, 1'b0, P, {KC, KB, KA}, 2, 6, 1, 0, 5);
        run_block(1'b1, 1'b0, D, {K, K, K}, 2, 1, 3, 0, -1);
        chk64("post_reset_out", last_out, 64'h85E813540F0AB405);

        for (int n = 0; n < 30; n++) begin
            for (int j = 0; j < 3; j++) begin
                dd[j] = int'($urandom_range(0, 11));
                dd[j] = (dd[j] == 0) ? 0 : 1 + (dd[j] - 1) % (T + 1);
            end
            run_block(1'($urandom), 1'($urandom), {$urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                      dd[0], dd[1], dd[2], int'($urandom_range(0, 3)), -1);
            idle(int'($urandom_range(0, 2)));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
